oki_adpcm_encoder: RTL

- Streaming 4-bit OKI/Dialogic ADPCM encoder. It is the write-side counterpart of the single-voice phrase playback decoder.
- Accepts 12-bit signed PCM samples and quantises each one against a local predictor that is bit-exact with the playback decoder.
- Packs two nibbles per byte, high nibble first, and emits addressed bytes for writing into phrase sample memory.
- Sits between a PCM capture/test source and the sample RAM/ROM loader.

---
 rtl/adpcm_pkg.sv | 33 +++
 rtl/oki_step_table.sv | 15 +
 rtl/oki_adpcm_encoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/adpcm_pkg.sv
// Shared OKI ADPCM constants: step table, index adjust, PCM limits and encoder states.
// The decoder LUT generation reads the same table, so both sides stay bit-exact.
package adpcm_pkg;

    localparam int STEP_CNT = 49;

    localparam logic signed [12:0] PCM_MIN = -13'sd2048;
    localparam logic signed [12:0] PCM_MAX = 13'sd2047;

    localparam logic [10:0] STEP_TABLE [STEP_CNT] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    // Indexed by the magnitude bits of a nibble.
    localparam logic signed [4:0] IDX_ADJ [8] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_IN = 3'd1,
        QUANT   = 3'd2,
        UPDATE  = 3'd3,
        EMIT    = 3'd4
    } state_t;

endpackage

// File: rtl/oki_step_table.sv
// Combinational step-index to quantiser step lookup.
module oki_step_table
    import adpcm_pkg::*;
(
    input  logic [5:0]  idx,
    output logic [10:0] step
);

    always_comb begin
        step = STEP_TABLE[STEP_CNT-1];
        if (idx < 6'(STEP_CNT))
            step = STEP_TABLE[idx];
    end

endmodule

// File: rtl/oki_adpcm_encoder.sv
// Streaming 4-bit OKI ADPCM encoder: quantises 12-bit PCM against a decoder-exact
// predictor and packs two nibbles per byte (high first) for phrase memory writes.
module oki_adpcm_encoder
    import adpcm_pkg::*;
#(
    parameter int PRED_INIT = -2,
    parameter int IDX_MAX   = 48
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [17:0] START_ADDR,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [11:0] IN_SAMPLE,
    input  logic        IN_LAST,
    output logic        BYTE_VALID,
    input  logic        BYTE_READY,
    output logic [7:0]  BYTE_DATA,
    output logic [17:0] BYTE_ADDR,
    output logic        BYTE_LAST,
    output logic [17:0] END_ADDR,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  NIB_OUT
);

    localparam logic signed [11:0] PRED0   = 12'(PRED_INIT);
    localparam logic [5:0]         IDX_TOP = 6'(IDX_MAX);

    state_t             state_q, state_d;
    logic [17:0]        addr_q, end_addr_q;
    logic signed [11:0] pred_q, x_q;
    logic [5:0]         idx_q;
    logic               phase_lo_q, last_q, byte_last_q, done_q;
    logic [7:0]         hold_q;
    logic [3:0]         nib_q, nib_out_q;
    logic [10:0]        step;

    oki_step_table u_step (
        .idx  (idx_q),
        .step (step)
    );

    // Quantiser: successive approximation of |x - pred| against step, step/2, step/4.
    logic signed [12:0] d;
    logic [12:0]        mag, m1, m2;
    logic [2:0]         code;
    logic [3:0]         nib_d;

    always_comb begin
        d     = {x_q[11], x_q} - {pred_q[11], pred_q};
        mag   = d[12] ? (~d + 13'd1) : d;
        code  = 3'd0;
        m1    = mag;
        if (mag >= {2'b0, step}) begin
            code[2] = 1'b1;
            m1      = mag - {2'b0, step};
        end
        m2 = m1;
        if (m1 >= {3'b0, step[10:1]}) begin
            code[1] = 1'b1;
            m2      = m1 - {3'b0, step[10:1]};
        end
        if (m2 >= {4'b0, step[10:2]})
            code[0] = 1'b1;
        nib_d = {d[12], code};
    end

    // Predictor and index update, same arithmetic as the playback decoder.
    logic [12:0]        diff;
    logic signed [12:0] sum;
    logic signed [11:0] pred_d;
    logic signed [4:0]  adj;
    logic [7:0]         idx_sum;
    logic [5:0]         idx_d;

    always_comb begin
        diff = {5'b0, step[10:3]}
             + (nib_q[2] ? {2'b0, step}       : 13'd0)
             + (nib_q[1] ? {3'b0, step[10:1]} : 13'd0)
             + (nib_q[0] ? {4'b0, step[10:2]} : 13'd0);
        sum  = nib_q[3] ? ({pred_q[11], pred_q} - diff) : ({pred_q[11], pred_q} + diff);
        if (sum < PCM_MIN)
            pred_d = PCM_MIN[11:0];
        else if (sum > PCM_MAX)
            pred_d = PCM_MAX[11:0];
        else
            pred_d = sum[11:0];

        adj     = IDX_ADJ[nib_q[2:0]];
        idx_sum = {2'b0, idx_q} + {{3{adj[4]}}, adj};
        if (idx_sum[7])
            idx_d = 6'd0;
        else if (idx_sum > {2'b0, IDX_TOP})
            idx_d = IDX_TOP;
        else
            idx_d = idx_sum[5:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = WAIT_IN;
            WAIT_IN: if (IN_VALID) state_d = QUANT;
            QUANT:   state_d = UPDATE;
            UPDATE:  state_d = (phase_lo_q || last_q) ? EMIT : WAIT_IN;
            EMIT:    if (BYTE_READY) state_d = byte_last_q ? IDLE : WAIT_IN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            addr_q      <= '0;
            end_addr_q  <= '0;
            pred_q      <= PRED0;
            x_q         <= '0;
            idx_q       <= '0;
            phase_lo_q  <= 1'b0;
            last_q      <= 1'b0;
            byte_last_q <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= '0;
            nib_q       <= '0;
            nib_out_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (START) begin
                    addr_q      <= START_ADDR;
                    pred_q      <= PRED0;
                    idx_q       <= '0;
                    phase_lo_q  <= 1'b0;
                    byte_last_q <= 1'b0;
                end
                WAIT_IN: if (IN_VALID) begin
                    x_q    <= IN_SAMPLE;
                    last_q <= IN_LAST;
                end
                QUANT: nib_q <= nib_d;
                UPDATE: begin
                    pred_q    <= pred_d;
                    idx_q     <= idx_d;
                    nib_out_q <= nib_q;
                    if (!phase_lo_q) begin
                        // A final high nibble goes out with a zero low nibble.
                        hold_q      <= {nib_q, 4'h0};
                        phase_lo_q  <= !last_q;
                        byte_last_q <= last_q;
                    end else begin
                        hold_q[3:0] <= nib_q;
                        byte_last_q <= last_q;
                    end
                end
                EMIT: if (BYTE_READY) begin
                    addr_q      <= addr_q + 18'd1;
                    phase_lo_q  <= 1'b0;
                    byte_last_q <= 1'b0;
                    if (byte_last_q) begin
                        end_addr_q <= addr_q;
                        done_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign IN_READY   = (state_q == WAIT_IN);
    assign BYTE_VALID = (state_q == EMIT);
    assign BYTE_DATA  = hold_q;
    assign BYTE_ADDR  = addr_q;
    assign BYTE_LAST  = (state_q == EMIT) && byte_last_q;
    assign END_ADDR   = end_addr_q;
    assign BUSY       = (state_q != IDLE);
    assign DONE       = done_q;
    assign NIB_OUT    = nib_out_q;

endmodule
